// File: rtl/transform_2d_seq_pkg.sv
// Shared state encoding and index/rounding helpers for the 2-D inverse transform sequencer.
package transform_2d_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ROW     = 3'd1,
        S_ROW_CAP = 3'd2,
        S_COL     = 3'd3,
        S_COL_CAP = 3'd4,
        S_OUT     = 3'd5
    } state_t;

    function automatic int unsigned idx(input int unsigned r, input int unsigned c);
        return 4 * r + c;
    endfunction

    // Element k = 4r+c of the transposed block comes from element 4c+r of the source.
    function automatic int unsigned tr_idx(input int unsigned k);
        return idx(k % 4, k / 4);
    endfunction

    // Add half an LSB then arithmetic shift; one guard bit above the input keeps the add exact.
    function automatic logic signed [31:0] round_shift(input logic signed [31:0] x,
                                                       input int unsigned sh);
        logic signed [32:0] t;
        t = $signed({x[31], x}) + $signed(33'(1) << (sh - 1));
        t = t >>> sh;
        return t[31:0];
    endfunction

endpackage

// File: rtl/transform_2d_seq.sv
// Row/column sequencer for a 4x4 inverse transform that time-shares one external butterfly.
module transform_2d_seq
    import transform_2d_seq_pkg::*;
#(
    parameter int unsigned W           = 16,
    parameter int unsigned ROUND_SHIFT = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_dht,
    input  logic [16*W-1:0] in_coef,
    output logic            bf_ena,
    output logic            bf_dht_sel,
    output logic [16*W-1:0] bf_in,
    input  logic [16*W-1:0] bf_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [16*W-1:0] out_res
);

    state_t          state, state_nxt;
    logic [16*W-1:0] coef_buf;
    logic [16*W-1:0] res_q;
    logic            dht_q;
    logic [16*W-1:0] row_tr;
    logic [16*W-1:0] col_res;

    // Both passes read bf_out through the same transpose; only the column pass rounds.
    for (genvar k = 0; k < 16; k++) begin : g_xpose
        localparam int unsigned J = tr_idx(k);
        logic signed [W-1:0] x;
        assign x                    = bf_out[J*W +: W];
        assign row_tr[k*W +: W]     = x;
        assign col_res[k*W +: W]    = dht_q ? x : W'(round_shift(32'(x), ROUND_SHIFT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            coef_buf <= '0;
            res_q    <= '0;
            dht_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        coef_buf <= in_coef;
                        dht_q    <= in_dht;
                    end
                end
                S_ROW_CAP: coef_buf <= row_tr;
                S_COL_CAP: res_q    <= col_res;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        bf_ena    = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_ROW;
            end
            S_ROW: begin
                bf_ena    = 1'b1;
                state_nxt = S_ROW_CAP;
            end
            S_ROW_CAP: state_nxt = S_COL;
            S_COL: begin
                bf_ena    = 1'b1;
                state_nxt = S_COL_CAP;
            end
            S_COL_CAP: state_nxt = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bf_in      = coef_buf;
    assign bf_dht_sel = dht_q;
    assign out_res    = res_q;

endmodule

// File: tb/tb_transform_2d_seq.sv
// Self-checking bench for transform_2d_seq with a behavioural butterfly and 2-D reference model.
module tb_transform_2d_seq;

    localparam int W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            in_dht;
    logic [16*W-1:0] in_coef;
    logic            bf_ena;
    logic            bf_dht_sel;
    logic [16*W-1:0] bf_in;
    logic [16*W-1:0] bf_out;
    logic            out_valid;
    logic            out_ready;
    logic [16*W-1:0] out_res;

    int checks = 0;
    int errors = 0;

    transform_2d_seq #(.W(16), .ROUND_SHIFT(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dht    (in_dht),
        .in_coef   (in_coef),
        .bf_ena    (bf_ena),
        .bf_dht_sel(bf_dht_sel),
        .bf_in     (bf_in),
        .bf_out    (bf_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res)
    );

    always #5 clk = ~clk;

    // 1-D 4-point inverse transform (normal) or Hadamard (dht), element i of the result.
    function automatic logic signed [15:0] tf1(input logic signed [15:0] a, b, c, d,
                                               input bit dht, input int i);
        logic signed [15:0] e, f, g, h;
        if (dht) begin
            case (i)
                0: return a + b + c + d;
                1: return a + b - c - d;
                2: return a - b - c + d;
                default: return a - b + c - d;
            endcase
        end
        e = a + c;
        f = a - c;
        g = (b >>> 1) - d;
        h = b + (d >>> 1);
        case (i)
            0: return e + h;
            1: return f + g;
            2: return f - g;
            default: return e - h;
        endcase
    endfunction

    // External butterfly: each group of four inputs is one 1-D transform.
    always @(posedge clk) begin
        if (bf_ena) begin
            for (int r = 0; r < 4; r++)
                for (int i = 0; i < 4; i++)
                    bf_out[(4*r+i)*W +: W] <= tf1(bf_in[(4*r)*W +: W], bf_in[(4*r+1)*W +: W],
                                                  bf_in[(4*r+2)*W +: W], bf_in[(4*r+3)*W +: W],
                                                  bf_dht, i);
        end
    end
    logic bf_dht;
    assign bf_dht = bf_dht_sel;

    // Reference: transform rows, then columns, then round unless dht.
    function automatic logic [255:0] ref2d(input logic [255:0] coef, input bit dht);
        logic signed [15:0] m [4][4];
        logic signed [15:0] t [4][4];
        logic signed [15:0] u;
        logic [255:0] res;
        int v;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = coef[(4*r+c)*16 +: 16];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = tf1(m[r][0], m[r][1], m[r][2], m[r][3], dht, c);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                u = tf1(t[0][c], t[1][c], t[2][c], t[3][c], dht, r);
                v = dht ? int'(u) : ((int'(u) + 32) >>> 6);
                res[(4*r+c)*16 +: 16] = v[15:0];
            end
        return res;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns just after the accepting posedge.
    task automatic send(input logic [255:0] coef, input bit dht, input string name);
        in_coef  = coef;
        in_dht   = dht;
        in_valid = 1'b1;
        chk({name, " in_ready"}, 256'(in_ready), 256'(1));
        @(posedge clk);
    endtask

    task automatic wait_out(input logic [255:0] exp, input bit dht, input string name);
        int n = 0;
        int ena_n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_coef  = {8{$urandom}};
            if (bf_ena) begin
                ena_n++;
                chk({name, " bf_dht_sel"}, 256'(bf_dht_sel), 256'(dht));
            end
            if (out_valid) begin
                n = i;
                break;
            end
        end
        chk({name, " latency"}, 256'(n), 256'(5));
        chk({name, " bf_ena_cycles"}, 256'(ena_n), 256'(2));
        chk({name, " out_res"}, out_res, exp);
        chk({name, " in_ready_busy"}, 256'(in_ready), 256'(0));
    endtask

    task automatic consume(input logic [255:0] exp, input int hold, input string name);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, " hold_valid"}, 256'(out_valid), 256'(1));
            chk({name, " hold_res"}, out_res, exp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, " post_valid"}, 256'(out_valid), 256'(0));
        chk({name, " post_ready"}, 256'(in_ready), 256'(1));
    endtask

    typedef struct {
        logic [255:0] coef;
        bit           dht;
        logic [255:0] exp;
        string        name;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [255:0] coef, exp, row_ac;
        bit dht;

        row_ac = {4{16'hFFFF, 16'h0000, 16'h0001, 16'h0001}};
        tbl[0] = '{256'd64, 1'b0, {16{16'h0001}}, "dc"};
        tbl[1] = '{{240'd0, 16'hFFC0}, 1'b0, {16{16'hFFFF}}, "neg_dc"};
        tbl[2] = '{{224'd0, 16'd64, 16'd0}, 1'b0, row_ac, "ac"};
        tbl[3] = '{256'd4, 1'b1, {16{16'h0004}}, "dht"};

        rst = 1'b1;
        in_valid = 1'b0;
        in_dht = 1'b0;
        in_coef = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst in_ready", 256'(in_ready), 256'(1));
        chk("rst out_valid", 256'(out_valid), 256'(0));
        chk("rst bf_ena", 256'(bf_ena), 256'(0));
        chk("rst bf_dht_sel", 256'(bf_dht_sel), 256'(0));
        chk("rst out_res", out_res, '0);
        chk("rst bf_in", bf_in, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            send(tbl[i].coef, tbl[i].dht, tbl[i].name);
            wait_out(tbl[i].exp, tbl[i].dht, tbl[i].name);
            consume(tbl[i].exp, 1, tbl[i].name);
        end

        // Backpressure with a second block waiting at the input.
        send(tbl[0].coef, 1'b0, "bp_a");
        wait_out(tbl[0].exp, 1'b0, "bp_a");
        in_coef  = tbl[2].coef;
        in_dht   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp hold_valid", 256'(out_valid), 256'(1));
            chk("bp hold_res", out_res, tbl[0].exp);
            chk("bp in_ready", 256'(in_ready), 256'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release_valid", 256'(out_valid), 256'(0));
        chk("bp second_ready", 256'(in_ready), 256'(1));
        @(posedge clk);
        wait_out(tbl[2].exp, 1'b0, "bp_b");
        consume(tbl[2].exp, 0, "bp_b");

        // Reset while the column pass is running.
        send(256'd4, 1'b1, "rst_mid");
        for (int i = 0; i < 3; i++) @(negedge clk);
        in_valid = 1'b0;
        chk("rst_mid in_col", 256'(bf_ena), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid out_valid", 256'(out_valid), 256'(0));
        chk("rst_mid in_ready", 256'(in_ready), 256'(1));
        chk("rst_mid bf_ena", 256'(bf_ena), 256'(0));
        chk("rst_mid bf_dht_sel", 256'(bf_dht_sel), 256'(0));
        chk("rst_mid bf_in", bf_in, '0);
        rst = 1'b0;
        @(negedge clk);
        send(tbl[1].coef, 1'b0, "after_rst");
        wait_out(tbl[1].exp, 1'b0, "after_rst");
        consume(tbl[1].exp, 0, "after_rst");

        // Random blocks against the reference model.
        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < 16; k++)
                coef[k*16 +: 16] = (n < 12) ? 16'(32'($urandom_range(0, 1023)) - 32'd512)
                                            : 16'($urandom);
            dht = 1'($urandom_range(0, 1));
            exp = ref2d(coef, dht);
            send(coef, dht, "rand");
            wait_out(exp, dht, "rand");
            consume(exp, int'($urandom_range(0, 2)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
